// File: rtl/cpu_mem_port.sv
// Purpose : CPU-side memory port with address-window decode, mirroring,
//           programmable wait states, optional read-only mode and error pulse.
// Latency : read data registered; valid in RESP, WAIT cycles of stall before it.
// Backpr. : rdy=0 while BUSY stalls the CPU; requests are only taken when rdy=1.
//
// Ports
//   clk      - single clock, all state on rising edge
//   rst      - synchronous active-low reset (storage is not cleared)
//   addr_out - CPU address            data_out - CPU write data
//   ren/wen  - read / write request   data_in  - registered read data to CPU
//   rdy      - 1 = CPU may proceed    err      - one-cycle pulse on illegal request
module cpu_mem_port #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 2048,
    parameter int BASE   = 0,
    parameter int SPAN   = 8192,
    parameter int WAIT   = 0,
    parameter int RO     = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr_out,
    input  logic [DATA_W-1:0] data_out,
    input  logic              ren,
    input  logic              wen,
    output logic [DATA_W-1:0] data_in,
    output logic              rdy,
    output logic              err
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // One extra bit so BASE+SPAN at the top of the address space stays exact.
    typedef logic [ADDR_W:0]    ext_addr_t;
    typedef logic [IDX_W-1:0]   idx_t;
    typedef logic [3:0]         cnt_t;

    localparam ext_addr_t WIN_LO = ext_addr_t'(BASE);
    localparam ext_addr_t WIN_HI = ext_addr_t'(BASE + SPAN);
    localparam cnt_t      WAIT_C = cnt_t'(WAIT);
    localparam logic      RO_B   = (RO != 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [DATA_W-1:0]   r_mem [DEPTH];
    logic [DATA_W-1:0]   r_rdat;
    logic                r_err;
    cnt_t                r_cnt;

    // Request captured at acceptance, replayed when the wait states expire.
    idx_t                r_idx;
    logic [DATA_W-1:0]   r_wdat;
    logic                r_rd;
    logic                r_wr;

    ext_addr_t           w_addr_x;
    idx_t                w_idx;
    logic                w_req;
    logic                w_accept;
    logic                w_in_win;
    logic                w_legal;
    logic                w_start_wait;

    // Access actually performed this edge (from live inputs or latched copy).
    logic                w_do_rd;
    logic                w_do_wr;
    idx_t                w_do_idx;
    logic [DATA_W-1:0]   w_do_dat;

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    assign w_addr_x = {1'b0, addr_out};
    // Truncating the window offset to IDX_W bits is the mod-DEPTH mirror.
    assign w_idx    = idx_t'(w_addr_x - WIN_LO);
    assign w_in_win = (w_addr_x >= WIN_LO) && (w_addr_x < WIN_HI);
    assign w_legal  = (ren ^ wen) && w_in_win && !(wen && RO_B);

    assign w_req        = ren | wen;
    assign w_accept     = (r_state != S_BUSY) && w_req;
    assign w_start_wait = w_accept && w_legal && (WAIT_C != 4'd0);

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and access strobes
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_do_rd     = 1'b0;
        w_do_wr     = 1'b0;
        w_do_idx    = w_idx;
        w_do_dat    = data_out;
        rdy         = (r_state != S_BUSY);

        case (r_state)
            S_IDLE, S_RESP: begin
                if (w_accept) begin
                    if (!w_legal) begin
                        // Illegal: no stall, straight to RESP with err.
                        w_state_nxt = S_RESP;
                    end else if (WAIT_C == 4'd0) begin
                        w_state_nxt = S_RESP;
                        w_do_rd     = ren;
                        w_do_wr     = wen;
                    end else begin
                        w_state_nxt = S_BUSY;
                    end
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_BUSY: begin
                // <= 1 rather than == 1 so a corrupted count cannot hang BUSY.
                if (r_cnt <= 4'd1) begin
                    w_state_nxt = S_RESP;
                    w_do_rd     = r_rd;
                    w_do_wr     = r_wr;
                    w_do_idx    = r_idx;
                    w_do_dat    = r_wdat;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Storage: never reset; a write that coincides with reset is dropped,
    // which is how an access abandoned in BUSY is cancelled.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst && w_do_wr) begin
            r_mem[w_do_idx] <= w_do_dat;
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rdat <= '0;
            r_err  <= 1'b0;
            r_cnt  <= '0;
            r_idx  <= '0;
            r_wdat <= '0;
            r_rd   <= 1'b0;
            r_wr   <= 1'b0;
        end else begin
            // err is only ever high in the RESP cycle following an illegal
            // acceptance; BUSY never accepts, so it clears there too.
            r_err <= w_accept && !w_legal;

            if (w_do_rd) begin
                r_rdat <= r_mem[w_do_idx];
            end

            if (w_start_wait) begin
                r_cnt  <= WAIT_C;
                r_idx  <= w_idx;
                r_wdat <= data_out;
                r_rd   <= ren;
                r_wr   <= wen;
            end else if ((r_state == S_BUSY) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end
        end
    end

    assign data_in = r_rdat;
    assign err     = r_err;

endmodule

// File: tb/tb_cpu_mem_port.sv
// Purpose : directed self-checking bench for cpu_mem_port over four
//           parameter sets (WAIT=0, WAIT=3, RO=1, WAIT=4) sharing one clock.
// Latency : expected read data queued at drive time, popped at RESP.
// Backpr. : each access waits on rdy with a bounded cycle budget.
module tb_cpu_mem_port;

    logic        clk;
    logic        rst_n [4];
    logic [15:0] a     [4];
    logic [7:0]  d     [4];
    logic        re    [4];
    logic        we    [4];
    logic [7:0]  q     [4];
    logic        rdy   [4];
    logic        err   [4];

    // Reference storage and last-read value per instance.
    logic [7:0]  mdl  [4][2048];
    logic [7:0]  last [4];
    logic [7:0]  sb_q [$];

    int checks = 0;
    int errors = 0;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        cpu_mem_port #(
            .ADDR_W (16),
            .DATA_W (8),
            .DEPTH  (2048),
            .BASE   (0),
            .SPAN   (8192),
            .WAIT   ((g == 1) ? 3 : ((g == 3) ? 4 : 0)),
            .RO     ((g == 2) ? 1 : 0)
        ) u_dut (
            .clk      (clk),
            .rst      (rst_n[g]),
            .addr_out (a[g]),
            .data_out (d[g]),
            .ren      (re[g]),
            .wen      (we[g]),
            .data_in  (q[g]),
            .rdy      (rdy[g]),
            .err      (err[g])
        );
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One complete request: drive, wait out the stall, check RESP, check the
    // cycle after RESP (err cleared, back in IDLE).
    task automatic do_access(input int i, input logic r, input logic w,
                             input logic [15:0] addr, input logic [7:0] dat,
                             input logic exp_err, input int exp_stall,
                             input logic chk_d);
        logic [7:0] expd;
        int         stalls;
        if (!exp_err && r) begin
            expd    = mdl[i][addr[10:0]];
            last[i] = expd;
        end else begin
            expd = last[i];
            if (!exp_err && w) mdl[i][addr[10:0]] = dat;
        end
        if (chk_d) sb_q.push_back(expd);

        @(negedge clk);
        a[i] = addr; d[i] = dat; re[i] = r; we[i] = w;
        @(negedge clk);
        re[i] = 1'b0; we[i] = 1'b0;
        stalls = 0;
        while (rdy[i] !== 1'b1 && stalls < 40) begin
            stalls++;
            @(negedge clk);
        end
        chk($sformatf("stall_i%0d_a%h", i, addr), stalls, exp_stall);
        chk($sformatf("err_i%0d_a%h", i, addr), err[i], exp_err);
        if (chk_d && sb_q.size() > 0)
            chk($sformatf("rdata_i%0d_a%h", i, addr), q[i], sb_q.pop_front());
        @(negedge clk);
        chk($sformatf("err_clr_i%0d_a%h", i, addr), err[i], 1'b0);
        chk($sformatf("idle_rdy_i%0d_a%h", i, addr), rdy[i], 1'b1);
    endtask

    initial begin
        logic [7:0] prior;
        for (int i = 0; i < 4; i++) begin
            rst_n[i] = 1'b0; a[i] = '0; d[i] = '0; re[i] = 1'b0; we[i] = 1'b0;
            last[i]  = 8'h00;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rst_rdy_i%0d", i), rdy[i], 1'b1);
            chk($sformatf("rst_err_i%0d", i), err[i], 1'b0);
            chk($sformatf("rst_data_i%0d", i), q[i], 8'h00);
            rst_n[i] = 1'b1;
        end

        // Zero wait: write then read back, no stall.
        do_access(0, 1'b0, 1'b1, 16'h0012, 8'hA5, 1'b0, 0, 1'b1);
        do_access(0, 1'b1, 1'b0, 16'h0012, 8'h00, 1'b0, 0, 1'b1);

        // Mirroring across the window.
        do_access(0, 1'b0, 1'b1, 16'h0005, 8'h3C, 1'b0, 0, 1'b1);
        do_access(0, 1'b1, 1'b0, 16'h0805, 8'h00, 1'b0, 0, 1'b1);
        do_access(0, 1'b1, 1'b0, 16'h1805, 8'h00, 1'b0, 0, 1'b1);

        // Top address of window aliases the top storage word.
        do_access(0, 1'b0, 1'b1, 16'h1FFF, 8'h42, 1'b0, 0, 1'b1);
        do_access(0, 1'b1, 1'b0, 16'h07FF, 8'h00, 1'b0, 0, 1'b1);

        // Back-to-back reads accepted in RESP without an IDLE cycle.
        @(negedge clk);
        a[0] = 16'h0012; re[0] = 1'b1;
        sb_q.push_back(8'hA5);
        @(negedge clk);
        chk("b2b_rdy0", rdy[0], 1'b1);
        chk("b2b_data0", q[0], sb_q.pop_front());
        a[0] = 16'h0805;
        sb_q.push_back(8'h3C);
        @(negedge clk);
        re[0] = 1'b0;
        chk("b2b_rdy1", rdy[0], 1'b1);
        chk("b2b_data1", q[0], sb_q.pop_front());
        last[0] = 8'h3C;
        @(negedge clk);

        // Out-of-window read and ren=wen=1 are illegal: err, data held.
        do_access(0, 1'b0, 1'b1, 16'h0100, 8'h77, 1'b0, 0, 1'b1);
        do_access(0, 1'b1, 1'b0, 16'h0100, 8'h00, 1'b0, 0, 1'b1);
        do_access(0, 1'b1, 1'b0, 16'h2000, 8'h00, 1'b1, 0, 1'b1);
        do_access(0, 1'b1, 1'b1, 16'h0100, 8'h00, 1'b1, 0, 1'b1);
        do_access(0, 1'b1, 1'b0, 16'h0100, 8'h00, 1'b0, 0, 1'b1);

        // Three wait states; illegal request still has no stall.
        do_access(1, 1'b0, 1'b1, 16'h0003, 8'h5A, 1'b0, 3, 1'b1);
        do_access(1, 1'b1, 1'b0, 16'h0003, 8'h00, 1'b0, 3, 1'b1);
        do_access(1, 1'b1, 1'b0, 16'h2003, 8'h00, 1'b1, 0, 1'b1);

        // Read-only window: capture prior content, write is rejected.
        do_access(2, 1'b1, 1'b0, 16'h0000, 8'h00, 1'b0, 0, 1'b0);
        prior        = q[2];
        mdl[2][0]    = prior;
        last[2]      = prior;
        do_access(2, 1'b0, 1'b1, 16'h0000, 8'hFF, 1'b1, 0, 1'b1);
        do_access(2, 1'b1, 1'b0, 16'h0000, 8'h00, 1'b0, 0, 1'b1);

        // Reset in BUSY abandons a pending write.
        do_access(3, 1'b0, 1'b1, 16'h0040, 8'h11, 1'b0, 4, 1'b1);
        do_access(3, 1'b1, 1'b0, 16'h0040, 8'h00, 1'b0, 4, 1'b1);
        @(negedge clk);
        a[3] = 16'h0040; d[3] = 8'h99; we[3] = 1'b1;
        @(negedge clk);
        we[3] = 1'b0;
        chk("rstbusy_rdy_low", rdy[3], 1'b0);
        @(negedge clk);
        rst_n[3] = 1'b0;
        @(negedge clk);
        chk("rstbusy_rdy", rdy[3], 1'b1);
        chk("rstbusy_err", err[3], 1'b0);
        chk("rstbusy_data", q[3], 8'h00);
        rst_n[3] = 1'b1;
        last[3]  = 8'h00;
        @(negedge clk);
        chk("rstbusy_idle_rdy", rdy[3], 1'b1);
        do_access(3, 1'b1, 1'b0, 16'h0040, 8'h00, 1'b0, 4, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_mem_port.md
CPU_MEM_PORT -- requirements
Module: cpu_mem_port

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, CPU address width.
REQ-002 SHALL have parameter DATA_W, default 8, data width.
REQ-003 SHALL have parameter DEPTH, default 2048, storage words; power of two.
REQ-004 SHALL have parameter BASE, default 0, first address of decode window.
REQ-005 SHALL have parameter SPAN, default 8192, window size in addresses; integer multiple of DEPTH (mirroring).
REQ-006 SHALL have parameter WAIT, default 0, range 0-15, stall cycles per legal access.
REQ-007 SHALL have parameter RO, default 0, 1 = whole window read-only.
REQ-008 SHALL have port clk, input, 1, the single clock; all state on rising edge.
REQ-009 SHALL have port rst, input, 1, synchronous active-low reset.
REQ-010 SHALL have port addr_out, input, ADDR_W, CPU address.
REQ-011 SHALL have port data_out, input, DATA_W, CPU write data.
REQ-012 SHALL have port ren, input, 1, read request.
REQ-013 SHALL have port wen, input, 1, write request.
REQ-014 SHALL have port data_in, output, DATA_W, registered read data to CPU.
REQ-015 SHALL have port rdy, output, 1, 1 = CPU may proceed, 0 = stall.
REQ-016 SHALL have port err, output, 1, one-cycle pulse on illegal request.

Function
REQ-017 SHALL implement states IDLE, BUSY, RESP; rdy=1 in IDLE and RESP, rdy=0 in BUSY.
REQ-018 SHALL accept a request on any edge in IDLE or RESP where ren|wen=1, latching addr_out, data_out, ren, wen.
REQ-019 SHALL treat a request as legal iff exactly one of ren/wen is 1, BASE <= addr_out < BASE+SPAN, and not (wen=1 and RO=1).
REQ-020 SHALL compute storage index as (addr_out-BASE) mod DEPTH, so every DEPTH-sized copy within the window aliases the same word.
REQ-021 SHALL, for a legal request with WAIT=0, perform the access at the acceptance edge and enter RESP.
REQ-022 SHALL, for a legal request with WAIT>0, load cnt=WAIT and enter BUSY; in BUSY decrement cnt each edge; at the edge where cnt=1, perform the access and enter RESP (exactly WAIT cycles of rdy=0).
REQ-023 SHALL, on a legal read access, update data_in with the addressed word; data_in is valid in RESP and holds until the next completed legal read.
REQ-024 SHALL, on a legal write access, store latched data_out; data_in unchanged.
REQ-025 SHALL, for an illegal request, perform no storage access, leave data_in unchanged (open bus), enter RESP without stall, and assert err for that RESP cycle only.
REQ-026 SHALL return to IDLE from RESP when no request is present; back-to-back requests in RESP are accepted without an IDLE cycle.
REQ-027 SHALL ignore ren/wen/addr_out/data_out while in BUSY; the latched values are used.
REQ-028 SHALL keep err=0 in IDLE and BUSY.
REQ-029 SHALL make address arithmetic ADDR_W+1 bits wide so BASE+SPAN at the top of the address space does not wrap.

Reset
REQ-030 SHALL, when rst=0 at a rising edge, enter IDLE with rdy=1, err=0, data_in=0, cnt=0, regardless of current state.
REQ-031 SHALL abandon an access in BUSY on reset mid-operation; a pending write is not performed.
REQ-032 SHALL not clear storage contents on reset.

Verification
REQ-033 SHALL cover: WAIT=0, write 8'hA5 to 16'h0012, read 16'h0012 -> rdy never 0, data_in=8'hA5 in the cycle after read acceptance, err=0.
REQ-034 SHALL cover: DEPTH=2048, SPAN=8192, write 8'h3C to 16'h0005, read 16'h0805 and 16'h1805 -> both return 8'h3C.
REQ-035 SHALL cover: WAIT=3, read request -> rdy=0 for exactly 3 cycles, then RESP with rdy=1 and valid data_in.
REQ-036 SHALL cover: read 16'h2000 (outside window) after a read returning 8'h77 -> err=1 for one cycle, data_in stays 8'h77; ren=wen=1 -> err=1, storage unchanged.
REQ-037 SHALL cover: RO=1, write 8'hFF to 16'h0000 -> err=1, subsequent read returns prior content.
REQ-038 SHALL cover: WAIT=4, write accepted, rst=0 asserted two cycles later -> next cycle IDLE, rdy=1, data_in=0, later read shows write not performed.
